// File: rtl/fifo_pkg.sv
// fifo_pkg: shared pointer types and Gray/binary helpers for both FIFO clock domains
package fifo_pkg;
    localparam int DEF_ADDRSIZE = 4;
    typedef logic [DEF_ADDRSIZE:0] ptr_t;
    function automatic ptr_t bin2gray(input ptr_t b);
        return (b >> 1) ^ b;
    endfunction
    function automatic ptr_t gray2bin(input ptr_t g);
        ptr_t b;
        b[DEF_ADDRSIZE] = g[DEF_ADDRSIZE];
        for (int i = DEF_ADDRSIZE - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction
endpackage

// File: rtl/wptr_full_lvl_if.sv
// wptr_full_lvl_if: write-side status bus between producer and write-pointer controller
interface wptr_full_lvl_if import fifo_pkg::*; #(parameter int ADDRSIZE = DEF_ADDRSIZE);
    logic                winc;
    logic [ADDRSIZE:0]   wrptr2;
    logic [ADDRSIZE:0]   wptr;
    logic [ADDRSIZE-1:0] waddr;
    logic                wfull;
    logic [ADDRSIZE:0]   wlevel;
    logic                woverflow;
    logic                wafull;
    modport master(output winc, wrptr2, input wptr, waddr, wfull, wlevel, woverflow, wafull);
    modport slave(input winc, wrptr2, output wptr, waddr, wfull, wlevel, woverflow, wafull);
endinterface

// File: rtl/gray2bin_conv.sv
// gray2bin_conv: combinational Gray-to-binary converter of parameterized width
module gray2bin_conv import fifo_pkg::*; #(parameter int W = DEF_ADDRSIZE + 1) (
    input  logic [W-1:0] g,
    output logic [W-1:0] b
);
    for (genvar i = 0; i < W; i++) begin : g_bit
        assign b[i] = ^g[W-1:i];
    end
endmodule

// File: rtl/wptr_full_lvl.sv
// wptr_full_lvl: write pointer, full, fill level, sticky overflow and almost-full for a Gray FIFO
// Almost-full compare is built only when WPTR_FULL_AFULL_EN is defined; otherwise wafull is tied low.
module wptr_full_lvl import fifo_pkg::*; #(
    parameter int ADDRSIZE     = DEF_ADDRSIZE,
    parameter int AFULL_MARGIN = 2
) (
    input logic wclk,
    input logic wrst,
    wptr_full_lvl_if.slave w
);
    localparam int DEPTH = 2 ** ADDRSIZE;
    logic [ADDRSIZE:0] wbin, rbin, wbnext, wgnext, lvl_next;
    logic              wmsb;
    if (AFULL_MARGIN < 1 || AFULL_MARGIN > DEPTH - 1) begin : g_bad_margin
        $error("AFULL_MARGIN out of range 1..DEPTH-1");
    end
    gray2bin_conv #(.W(ADDRSIZE + 1)) u_wbin (.g(w.wptr), .b(wbin));
    gray2bin_conv #(.W(ADDRSIZE + 1)) u_rbin (.g(w.wrptr2), .b(rbin));
    assign wbnext   = wbin + (ADDRSIZE + 1)'(w.winc & ~w.wfull);
    assign wgnext   = (wbnext >> 1) ^ wbnext;
    assign lvl_next = wbnext - rbin;
    // address MSB is the binary MSB of the lower ADDRSIZE bits, recovered from the two Gray MSBs
    assign w.waddr  = {wmsb, w.wptr[ADDRSIZE-2:0]};
    always_ff @(posedge wclk) begin
        if (wrst) begin
            w.wptr      <= '0;
            wmsb        <= 1'b0;
            w.wfull     <= 1'b0;
            w.wlevel    <= '0;
            w.woverflow <= 1'b0;
        end else begin
            w.wptr      <= wgnext;
            wmsb        <= wgnext[ADDRSIZE] ^ wgnext[ADDRSIZE-1];
            w.wfull     <= wgnext == {~w.wrptr2[ADDRSIZE:ADDRSIZE-1], w.wrptr2[ADDRSIZE-2:0]};
            w.wlevel    <= lvl_next;
            w.woverflow <= w.woverflow | (w.winc & w.wfull);
        end
    end
`ifdef WPTR_FULL_AFULL_EN
    localparam logic [ADDRSIZE:0] AF_TH = (ADDRSIZE + 1)'(DEPTH - AFULL_MARGIN);
    always_ff @(posedge wclk) begin
        if (wrst) w.wafull <= 1'b0;
        else w.wafull <= lvl_next >= AF_TH;
    end
`else
    assign w.wafull = 1'b0;
`endif
endmodule

// File: tb/tb_wptr_full_lvl.sv
// tb_wptr_full_lvl: scoreboard bench; a count-based FIFO model predicts every write-side output
module tb_wptr_full_lvl;
    localparam int AS = 4;
    localparam int DEPTH = 16;
    typedef struct {
        logic [4:0] wptr;
        logic [3:0] waddr;
        logic       wfull;
        logic [4:0] wlevel;
        logic       wover;
        logic       wafull;
    } exp_t;
    logic wclk = 1'b0;
    logic wrst;
    exp_t q[$];
    int   tests = 0, fails = 0;
    int   m_wc = 0, m_rc = 0, m_lvl = 0;
    bit   m_full = 0, m_over = 0;
    wptr_full_lvl_if #(.ADDRSIZE(AS)) bus ();
    wptr_full_lvl #(.ADDRSIZE(AS), .AFULL_MARGIN(2)) dut (.wclk(wclk), .wrst(wrst), .w(bus.slave));
    always #5 wclk = ~wclk;
    function automatic logic [4:0] gray(input int v);
        logic [4:0] b;
        b = v[4:0];
        return b ^ (b >> 1);
    endfunction
    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
        end
    endtask
    // one wclk cycle: drive inputs, advance the model by FIFO counting rules, queue the prediction
    task automatic step(input bit rst, input bit inc, input int rc);
        exp_t e;
        logic [4:0] g;
        @(negedge wclk);
        wrst = rst;
        bus.winc = inc;
        bus.wrptr2 = gray(rc);
        if (rst) begin
            m_wc = 0; m_rc = 0; m_lvl = 0; m_full = 0; m_over = 0;
        end else begin
            m_over = m_over | (inc & m_full);
            if (inc && !m_full) m_wc++;
            m_rc = rc;
            m_lvl = m_wc - m_rc;
            m_full = (m_lvl == DEPTH);
        end
        g = gray(m_wc);
        e.wptr = g;
        e.waddr = {g[4] ^ g[3], g[2:0]};
        e.wfull = m_full;
        e.wlevel = 5'(m_lvl);
        e.wover = m_over;
`ifdef WPTR_FULL_AFULL_EN
        e.wafull = (m_lvl >= DEPTH - 2);
`else
        e.wafull = 1'b0;
`endif
        q.push_back(e);
    endtask
    task automatic rnd(input int n);
        for (int i = 0; i < n; i++) begin
            int rp;
            bit rd;
            rp = ((i / 80) % 2) ? 3 : 1;
            rd = ($urandom % 4) < rp;
            step(0, ($urandom % 4) != 0, m_rc + ((rd && m_rc < m_wc) ? 1 : 0));
        end
    endtask
    initial begin
        forever begin
            @(posedge wclk);
            #1;
            if (q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                chk("wptr", 32'(bus.wptr), 32'(e.wptr));
                chk("waddr", 32'(bus.waddr), 32'(e.waddr));
                chk("wfull", 32'(bus.wfull), 32'(e.wfull));
                chk("wlevel", 32'(bus.wlevel), 32'(e.wlevel));
                chk("woverflow", 32'(bus.woverflow), 32'(e.wover));
                chk("wafull", 32'(bus.wafull), 32'(e.wafull));
            end
        end
    end
    initial begin
        wrst = 1'b1;
        bus.winc = 1'b0;
        bus.wrptr2 = '0;
        step(1, 1, 0);
        step(1, 1, 0);
        repeat (16) step(0, 1, 0);
        step(0, 1, 0);
        repeat (2) step(0, 0, 0);
        step(0, 0, 4);
        step(0, 1, 4);
        step(0, 0, 4);
        rnd(700);
        step(1, 0, 0);
        while (m_lvl < 9) step(0, 1, m_rc);
        step(1, 1, m_rc);
        rnd(200);
        @(posedge wclk);
        #2;
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
